// File: rtl/vga_overlay_ctrl.sv
// VGA timing generator with a small double-buffered rectangle overlay.
// Pending object entries are committed to the live bank once per frame; RGB and syncs leave a 2-stage pipeline.
module vga_overlay_ctrl #(
    parameter int          H_ACTIVE  = 1280,
    parameter int          H_FP      = 48,
    parameter int          H_SYNC    = 112,
    parameter int          H_BP      = 248,
    parameter int          V_ACTIVE  = 1024,
    parameter int          V_FP      = 1,
    parameter int          V_SYNC    = 3,
    parameter int          V_BP      = 38,
    parameter int          NUM_OBJ   = 4,
    parameter logic        SYNC_POL  = 1'b1,
    parameter logic [11:0] BG_COLOUR = 12'h000,
    localparam int         IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             obj_wr_en,
    input  logic [IDX_W-1:0] obj_wr_idx,
    input  logic [11:0]      obj_x,
    input  logic [11:0]      obj_y,
    input  logic [7:0]       obj_w,
    input  logic [7:0]       obj_h,
    input  logic [11:0]      obj_colour,
    input  logic             obj_visible,
    output logic [3:0]       vgaRed,
    output logic [3:0]       vgaGreen,
    output logic [3:0]       vgaBlue,
    output logic             Hsync,
    output logic             Vsync,
    output logic             frame_start
);

    localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] H_SS     = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SE     = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_SS     = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SE     = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [IDX_W:0] IDX_LIM = (IDX_W + 1)'(NUM_OBJ);

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [11:0] colour;
        logic        visible;
    } obj_t;

    logic [11:0]        hcnt_r;
    logic [11:0]        vcnt_r;
    obj_t               pending_r [NUM_OBJ];
    obj_t               live_r    [NUM_OBJ];
    logic               commit_s;
    logic               wr_ok_s;
    logic               active_s;
    logic               hsync_s;
    logic               vsync_s;
    logic               first_s;
    logic [NUM_OBJ-1:0] hit_s;
    logic [NUM_OBJ-1:0] hit1_r;
    logic               active1_r;
    logic               hsync1_r;
    logic               vsync1_r;
    logic               first1_r;
    logic [11:0]        rgb_s;
    logic [11:0]        rgb_r;
    logic               hsync_r;
    logic               vsync_r;
    logic               frame_start_r;

    assign commit_s = (hcnt_r == H_LAST) && (vcnt_r == V_LAST);
    assign wr_ok_s  = obj_wr_en && ({1'b0, obj_wr_idx} < IDX_LIM);

    // Raster position counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_r <= 12'd0;
            vcnt_r <= 12'd0;
        end else if (hcnt_r == H_LAST) begin
            hcnt_r <= 12'd0;
            vcnt_r <= (vcnt_r == V_LAST) ? 12'd0 : vcnt_r + 12'd1;
        end else begin
            hcnt_r <= hcnt_r + 12'd1;
        end
    end

    // Pending/live object banks; the commit copies the pre-write pending contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (reset) begin
                pending_r[i] <= '0;
                live_r[i]    <= '0;
            end else begin
                if (wr_ok_s && (obj_wr_idx == IDX_W'(i))) begin
                    pending_r[i] <= {obj_x, obj_y, obj_w, obj_h, obj_colour, obj_visible};
                end
                if (commit_s) begin
                    live_r[i] <= pending_r[i];
                end
            end
        end
    end

    // Hit test at 13 bits so right/bottom edges near 4095 never wrap around.
    always_comb begin
        active_s = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
        hit_s    = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            hit_s[i] = live_r[i].visible && active_s
                    && ({1'b0, hcnt_r} >= {1'b0, live_r[i].x})
                    && ({1'b0, hcnt_r} <  ({1'b0, live_r[i].x} + {5'd0, live_r[i].w}))
                    && ({1'b0, vcnt_r} >= {1'b0, live_r[i].y})
                    && ({1'b0, vcnt_r} <  ({1'b0, live_r[i].y} + {5'd0, live_r[i].h}));
        end
        hsync_s = ((hcnt_r >= H_SS) && (hcnt_r < H_SE)) ? SYNC_POL : ~SYNC_POL;
        vsync_s = ((vcnt_r >= V_SS) && (vcnt_r < V_SE)) ? SYNC_POL : ~SYNC_POL;
        first_s = (hcnt_r == 12'd0) && (vcnt_r == 12'd0);
    end

    // Stage 1: hit vector, active flag and raw timing.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit1_r    <= '0;
            active1_r <= 1'b0;
            hsync1_r  <= ~SYNC_POL;
            vsync1_r  <= ~SYNC_POL;
            first1_r  <= 1'b0;
        end else begin
            hit1_r    <= hit_s;
            active1_r <= active_s;
            hsync1_r  <= hsync_s;
            vsync1_r  <= vsync_s;
            first1_r  <= first_s;
        end
    end

    // Lowest index wins, so walk downward and let lower indices overwrite.
    always_comb begin
        rgb_s = BG_COLOUR;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            rgb_s = hit1_r[i] ? live_r[i].colour : rgb_s;
        end
        rgb_s = active1_r ? rgb_s : 12'h000;
    end

    // Stage 2: output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_r         <= 12'h000;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            frame_start_r <= 1'b0;
        end else begin
            rgb_r         <= rgb_s;
            hsync_r       <= hsync1_r;
            vsync_r       <= vsync1_r;
            frame_start_r <= first1_r;
        end
    end

    assign vgaRed      = rgb_r[11:8];
    assign vgaGreen    = rgb_r[7:4];
    assign vgaBlue     = rgb_r[3:0];
    assign Hsync       = hsync_r;
    assign Vsync       = vsync_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_overlay_ctrl.sv
// Scoreboard bench for vga_overlay_ctrl on a 24x12 raster with 3 objects.
// The driver predicts every output cycle from a behavioural model; a monitor compares them.
module tb_vga_overlay_ctrl;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NOBJ = 3;
    localparam logic [14:0] RST_OUT = 15'h0000;

    typedef struct {
        int          x;
        int          y;
        int          w;
        int          h;
        logic [11:0] col;
        bit          vis;
    } obj_t;

    typedef struct {
        logic [14:0] out;
        int          t;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        obj_wr_en;
    logic [1:0]  obj_wr_idx;
    logic [11:0] obj_x;
    logic [11:0] obj_y;
    logic [7:0]  obj_w;
    logic [7:0]  obj_h;
    logic [11:0] obj_colour;
    logic        obj_visible;
    logic [3:0]  vgaRed;
    logic [3:0]  vgaGreen;
    logic [3:0]  vgaBlue;
    logic        Hsync;
    logic        Vsync;
    logic        frame_start;

    vga_overlay_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .NUM_OBJ(NOBJ), .SYNC_POL(1'b1), .BG_COLOUR(12'h000)
    ) dut (
        .clk(clk), .reset(reset),
        .obj_wr_en(obj_wr_en), .obj_wr_idx(obj_wr_idx),
        .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
        .obj_colour(obj_colour), .obj_visible(obj_visible),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .Hsync(Hsync), .Vsync(Vsync), .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t        exp_q [$];
    int          checks = 0;
    int          passed = 0;
    int          cyc    = 0;
    obj_t        pend [NOBJ];
    obj_t        live [NOBJ];
    int          mh = 0;
    int          mv = 0;
    logic [14:0] prev_desc = RST_OUT;

    // Expected {R,G,B,Hsync,Vsync,frame_start} for raster position (h,v).
    function automatic logic [14:0] pixel_exp(int h, int v);
        logic [11:0] c;
        bit act, hs, vs, fs;
        act = (h < HA) && (v < VA);
        c   = 12'h000;
        for (int i = NOBJ - 1; i >= 0; i--) begin
            if (live[i].vis && h >= live[i].x && h < live[i].x + live[i].w &&
                v >= live[i].y && v < live[i].y + live[i].h)
                c = live[i].col;
        end
        if (!act) c = 12'h000;
        hs = (h >= HA + HF) && (h < HA + HF + HS);
        vs = (v >= VA + VF) && (v < VA + VF + VS);
        fs = (h == 0) && (v == 0);
        return {c, hs, vs, fs};
    endfunction

    function automatic obj_t mk(int x, int y, int w, int h, logic [11:0] c, bit vis);
        obj_t o;
        o.x = x; o.y = y; o.w = w; o.h = h; o.col = c; o.vis = vis;
        return o;
    endfunction

    // One clock: drive inputs, predict the output after this edge, advance the model.
    task automatic cycle(input bit rst, input bit we, input int idx, input obj_t o);
        exp_t e;
        reset       = rst;
        obj_wr_en   = we;
        obj_wr_idx  = idx[1:0];
        obj_x       = o.x[11:0];
        obj_y       = o.y[11:0];
        obj_w       = o.w[7:0];
        obj_h       = o.h[7:0];
        obj_colour  = o.col;
        obj_visible = o.vis;
        e.out = rst ? RST_OUT : prev_desc;
        e.t   = cyc;
        exp_q.push_back(e);
        prev_desc = rst ? RST_OUT : pixel_exp(mh, mv);
        if (rst) begin
            for (int i = 0; i < NOBJ; i++) begin
                pend[i] = mk(0, 0, 0, 0, 12'h000, 1'b0);
                live[i] = mk(0, 0, 0, 0, 12'h000, 1'b0);
            end
            mh = 0;
            mv = 0;
        end else begin
            if (mh == HT - 1 && mv == VT - 1) live = pend;
            if (we && idx < NOBJ) pend[idx] = o;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        cyc++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, mk(0, 0, 0, 0, 12'h000, 1'b0));
    endtask

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, mk(0, 0, 0, 0, 12'h000, 1'b0));
    endtask

    task automatic goto_pos(input int h, input int v);
        for (int i = 0; i < HT * VT + 1; i++) begin
            if (mh == h && mv == v) break;
            idle(1);
        end
    endtask

    task automatic wr(input int idx, input obj_t o);
        cycle(1'b0, 1'b1, idx, o);
    endtask

    // Monitor: compares each output cycle against the next scoreboard entry.
    always @(posedge clk) begin
        exp_t e;
        logic [14:0] got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {vgaRed, vgaGreen, vgaBlue, Hsync, Vsync, frame_start};
            checks++;
            if (got === e.out) passed++;
            else $display("FAIL out cycle=%0d got=%h exp=%h", e.t, got, e.out);
        end
    end

    initial begin
        obj_t o;
        rst_cycles(3);
        idle(2 * HT * VT);

        wr(0, mk(4, 2, 3, 2, 12'hF00, 1'b1));
        idle(2 * HT * VT);

        wr(0, mk(4, 2, 4, 4, 12'h0F0, 1'b1));
        wr(1, mk(6, 2, 4, 4, 12'h00F, 1'b1));
        idle(2 * HT * VT);

        goto_pos(0, 4);
        wr(0, mk(10, 2, 4, 4, 12'h0F0, 1'b1));
        idle(2 * HT * VT);
        goto_pos(HT - 1, VT - 1);
        wr(0, mk(2, 2, 4, 4, 12'h0F0, 1'b1));
        idle(2 * HT * VT);

        wr(1, mk(0, 0, 0, 0, 12'h000, 1'b0));
        wr(0, mk(14, 0, 8, 3, 12'hFFF, 1'b1));
        wr(2, mk(0, 4, 0, 3, 12'h0FF, 1'b1));
        wr(3, mk(0, 0, 16, 8, 12'hF0F, 1'b1));
        idle(2 * HT * VT);
        wr(0, mk(4095, 0, 255, 8, 12'hABC, 1'b1));
        idle(2 * HT * VT);

        wr(1, mk(3, 3, 5, 5, 12'h5A5, 1'b1));
        idle(2 * HT * VT);
        goto_pos(0, 5);
        rst_cycles(3);
        idle(2 * HT * VT);

        for (int i = 0; i < 4 * HT * VT; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                o.x   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 20));
                o.y   = int'($urandom_range(0, 10));
                o.w   = int'($urandom_range(0, 10));
                o.h   = int'($urandom_range(0, 6));
                o.col = 12'($urandom);
                o.vis = 1'($urandom_range(0, 1));
                wr(int'($urandom_range(0, 3)), o);
            end else begin
                idle(1);
            end
        end
        idle(4);

        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain left=%0d exp=0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_overlay_ctrl.md
VGA_OVERLAY_CTRL -- requirements
Module: vga_overlay_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: `clk` is the single clock, and `reset` is synchronous and active-high.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_ACTIVE, 1024, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- NUM_OBJ, 4, rectangle object count (1..8)
- SYNC_POL, 1, sync asserted level
- BG_COLOUR, 12'h000, background RGB444
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock
- reset, in, 1, synchronous active-high reset
- obj_wr_en, in, 1, object write strobe
- obj_wr_idx, in, $clog2(NUM_OBJ) (min 1), object index
- obj_x, in, 12, left edge
- obj_y, in, 12, top edge
- obj_w, in, 8, width
- obj_h, in, 8, height
- obj_colour, in, 12, RGB444 as [11:8]=R, [7:4]=G, [3:0]=B
- obj_visible, in, 1, enable
- vgaRed, out, 4, red
- vgaGreen, out, 4, green
- vgaBlue, out, 4, blue
- Hsync, out, 1, horizontal sync
- Vsync, out, 1, vertical sync
- frame_start, out, 1, first-pixel marker

Function
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-005 The counters SHALL behave as follows:
- hcnt counts 0..H_TOTAL-1 and wraps to 0.
- vcnt increments on the hcnt wrap and wraps to 0 after V_TOTAL-1.
- Both counters are 12 bits.
REQ-006 Timing signals SHALL be derived from the counters as follows:
- active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Hsync = SYNC_POL while hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), otherwise ~SYNC_POL.
- Vsync is the same on vcnt, using the V parameters.
REQ-007 When obj_wr_en=1, the block SHALL write {x, y, w, h, colour, visible} into pending entry obj_wr_idx; an index >= NUM_OBJ SHALL be ignored.
REQ-008 The block SHALL copy all pending entries into the live bank in the single cycle where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1 (the commit cycle).
- Live entries never change mid-frame.
REQ-009 A write in the commit cycle SHALL update the pending bank only and SHALL NOT be included in that commit.
REQ-010 Object i SHALL hit pixel (hcnt,vcnt) when all of the following hold:
- live visible = 1
- hcnt >= x and hcnt < x+w
- vcnt >= y and vcnt < y+h
- active = 1
Sums SHALL be computed at 13 bits with no wrap; w=0 or h=0 SHALL never hit.
REQ-011 Priority SHALL be: the lowest-index hitting object supplies the colour; if no object hits, BG_COLOUR is used; outside the active area, RGB = 0.
REQ-012 The pipeline SHALL be:
- Stage 1 registers the hit vector and active.
- Stage 2 registers the priority-muxed RGB.
- Latency from counter value to RGB is 2 cycles.
REQ-013 Hsync and Vsync SHALL be delayed by 2 registers so that they are cycle-aligned with the RGB for the same counter value.
REQ-014 frame_start SHALL be 1 for exactly one cycle, the cycle in which the outputs correspond to pixel (0,0).
REQ-015 The block SHALL clip rectangles that extend past H_ACTIVE/V_ACTIVE at the active edge, and SHALL NOT wrap them to the next line or frame.

Reset
REQ-016 While reset=1, the block SHALL hold:
- hcnt = vcnt = 0
- all pipeline registers cleared
- vgaRed = vgaGreen = vgaBlue = 0
- Hsync = Vsync = ~SYNC_POL
- frame_start = 0
- all pending and live entries zeroed (visible = 0)
REQ-017 Writes SHALL be ignored while reset=1.
REQ-018 In the first cycle after reset falls, the counters SHALL be at (0,0), and frame_start SHALL pulse 2 cycles after reset falls.
REQ-019 Reset asserted mid-frame SHALL abort the frame and restart it per REQ-016 to REQ-018.

Verification
REQ-020 The bench SHALL cover these directed scenarios, using H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1 (H_TOTAL=24, V_TOTAL=12):
- Timing: after reset release, frame_start recurs every 288 cycles; Hsync is at SYNC_POL for 3 cycles per line, starting at output column 18; Vsync is at SYNC_POL for 2 lines starting at line 9.
- Single object: write idx0 {x=4, y=2, w=3, h=2, colour=12'hF00, visible=1}, then wait one commit. Next frame: RGB=F,0,0 at columns 4..6 of lines 2..3 only, and 0 elsewhere.
- Overlap priority: idx0 {x=4, y=2, w=4, h=4, colour=12'h0F0}, idx1 {x=6, y=2, w=4, h=4, colour=12'h00F}. Columns 6..7 show G=F; columns 8..9 show B=F.
- Mid-frame write: write idx0 x=10 while vcnt=4. The current frame still shows the old x; the next frame shows x=10. A write in the commit cycle appears only after the following commit.
- Edge cases:
  - x=14, w=8 clips to columns 14..15.
  - w=0 shows nothing.
  - obj_wr_idx=NUM_OBJ has no effect.
  - x=4095, w=255 never hits.
- Reset mid-frame: assert reset at vcnt=5 for 3 cycles. Outputs go to their reset values; frame_start occurs 2 cycles after release; all objects are invisible until rewritten and committed.
